// File: rtl/sec_xfer_pkg.sv
// Shared encodings for the secure transfer controller: FSM state codes and
// transfer direction constants.
package sec_xfer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t RD   = 3'd1;
    localparam state_t WAIT = 3'd2;
    localparam state_t WR   = 3'd3;
    localparam state_t DONE = 3'd4;

    localparam logic DIR_M2R = 1'b0;
    localparam logic DIR_R2M = 1'b1;

endpackage

// File: rtl/sec_xfer_ctrl.sv
// Word-by-word copy engine between memory and register file, optionally routed
// through an external security block. Key comparison on start: SEC_XFER_KEY_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start; latches the transfer descriptor
// RD    | source address driven; zero-length transfers leave here for DONE
// WAIT  | source address held while read data returns
// WR    | one destination write, optionally via the security block
// DONE  | one-cycle completion pulse
module sec_xfer_ctrl
    import sec_xfer_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    input  logic              crypt,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [DATA_W-1:0] sec_din,
    output logic              sec_en,
    input  logic [DATA_W-1:0] sec_dout,
    input  logic [15:0]       key_mem,
    input  logic [15:0]       key_reg
);

    state_t            state_q, state_d;
    logic              dir_q, crypt_q, err_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, count_q;
    logic [DATA_W-1:0] word_q, wdata;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic              key_ok, last_word;

`ifdef SEC_XFER_KEY_CHECK_EN
    assign key_ok = (key_mem == key_reg);
`else
    logic unused_keys;
    assign unused_keys = ^{key_mem, key_reg};
    assign key_ok      = 1'b1;
`endif

    assign src_addr  = src_q + ADDR_W'(count_q);
    assign dst_addr  = dst_q + ADDR_W'(count_q);
    assign last_word = ((count_q + LEN_W'(1)) == len_q);
    assign wdata     = crypt_q ? sec_dout : word_q;

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = key_ok ? RD : DONE;
                RD:      state_d = (len_q == '0) ? DONE : WAIT;
                WAIT:    state_d = WR;
                WR:      state_d = last_word ? DONE : RD;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            crypt_q <= 1'b0;
            err_q   <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                err_q <= 1'b1;
            end else if (state_q == IDLE && start) begin
                dir_q   <= dir;
                src_q   <= src_base;
                dst_q   <= dst_base;
                len_q   <= len;
                crypt_q <= crypt;
                count_q <= '0;
                err_q   <= !key_ok;
            end else if (state_q == WR) begin
                count_q <= count_q + LEN_W'(1);
            end
            if (state_q == WAIT) begin
                word_q <= (dir_q == DIR_M2R) ? mem_rdata : reg_rdata;
            end
        end
    end

    // Outputs are gated by rst and abort directly so neither can let a write slip out.
    assign busy    = !rst && (state_q != IDLE);
    assign done    = !rst && !abort && (state_q == DONE);
    assign err     = !rst && err_q;
    assign sec_din = (!rst && state_q == WR) ? word_q : '0;
    assign sec_en  = !rst && (state_q == WR) && crypt_q;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        reg_addr  = '0;
        reg_we    = 1'b0;
        reg_wdata = '0;
        if (!rst) begin
            if (state_q == RD || state_q == WAIT) begin
                if (dir_q == DIR_M2R) mem_addr = src_addr;
                else                  reg_addr = src_addr;
            end else if (state_q == WR) begin
                if (dir_q == DIR_M2R) begin
                    reg_addr  = dst_addr;
                    reg_we    = !abort;
                    reg_wdata = wdata;
                end else begin
                    mem_addr  = dst_addr;
                    mem_we    = !abort;
                    mem_wdata = wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sec_xfer_ctrl.sv
// Self-checking bench for sec_xfer_ctrl: table of transfer vectors plus
// hand-written abort, key-check and mid-transfer reset sequences.
module tb_sec_xfer_ctrl;

    localparam logic [31:0] SEC_KEY = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst, start, dir, crypt, abort;
    logic [9:0]  src_base, dst_base;
    logic [10:0] len;
    logic        busy, done, err;
    logic [9:0]  mem_addr, reg_addr;
    logic        mem_we, reg_we, sec_en;
    logic [31:0] mem_wdata, mem_rdata, reg_wdata, reg_rdata, sec_din, sec_dout;
    logic [15:0] key_mem, key_reg;

    typedef struct packed {
        logic        is_mem;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic        dir;
        logic [9:0]  src;
        logic [9:0]  dst;
        logic [10:0] len;
        logic        crypt;
        int          lat;
    } vec_t;

    wr_t  wlog[$];
    int   cyc = 0;
    int   sec_cnt, sec_bad, done_cnt, dual_bad;
    int   checks = 0;
    int   errors = 0;
    int   n0;
    vec_t vecs[6];

    sec_xfer_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir),
        .src_base(src_base), .dst_base(dst_base), .len(len), .crypt(crypt),
        .abort(abort), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .sec_din(sec_din), .sec_en(sec_en), .sec_dout(sec_dout),
        .key_mem(key_mem), .key_reg(key_reg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input logic [9:0] a);
        return 32'h1000_0000 | {22'b0, a};
    endfunction

    function automatic logic [31:0] reg_init(input logic [9:0] a);
        return 32'h2000_0000 | {22'b0, a};
    endfunction

    assign sec_dout = sec_din ^ SEC_KEY;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_rdata <= mem_init(mem_addr);
        reg_rdata <= reg_init(reg_addr);
        if (mem_we) wlog.push_back('{1'b1, mem_addr, mem_wdata});
        if (reg_we) wlog.push_back('{1'b0, reg_addr, reg_wdata});
    end

    always @(negedge clk) begin
        if (sec_en) sec_cnt++;
        if (sec_en && !(mem_we || reg_we)) sec_bad++;
        if (mem_we && reg_we) dual_bad++;
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wlog.delete();
        sec_cnt  = 0;
        sec_bad  = 0;
        done_cnt = 0;
        dual_bad = 0;
    endtask

    // Presents a start for one cycle; returns just after the sampling edge with n0 set.
    task automatic do_start(input logic d, input logic [9:0] s, input logic [9:0] t,
                            input logic [10:0] l, input logic c);
        @(negedge clk);
        dir = d; src_base = s; dst_base = t; len = l; crypt = c; start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        start = 1'b0;
        dir = ~d; src_base = ~s; dst_base = ~t; len = 11'd7; crypt = ~c;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - n0 + 1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic [9:0]  sa, da;
        logic [31:0] w;
        clear_mon();
        do_start(v.dir, v.src, v.dst, v.len, v.crypt);
        wait_done(lat);
        chk({v.name, " done_latency"}, lat, v.lat);
        @(negedge clk);
        chk({v.name, " done_one_cycle"}, done, 1'b0);
        chk({v.name, " done_count"}, done_cnt, 1);
        chk({v.name, " busy_after"}, busy, 1'b0);
        chk({v.name, " err_clear"}, err, 1'b0);
        chk({v.name, " write_count"}, wlog.size(), {21'b0, v.len});
        for (int k = 0; k < wlog.size() && k < int'(v.len); k++) begin
            sa = v.src + 10'(k);
            da = v.dst + 10'(k);
            w  = (v.dir == 1'b0) ? mem_init(sa) : reg_init(sa);
            if (v.crypt) w = w ^ SEC_KEY;
            chk({v.name, " wr_port"}, wlog[k].is_mem, v.dir);
            chk({v.name, " wr_addr"}, wlog[k].addr, da);
            chk({v.name, " wr_data"}, wlog[k].data, w);
        end
        chk({v.name, " sec_en_cycles"}, sec_cnt, v.crypt ? int'(v.len) : 0);
        chk({v.name, " sec_en_outside_wr"}, sec_bad, 0);
        chk({v.name, " dual_we"}, dual_bad, 0);
    endtask

    initial begin
        int lat;
        vecs[0] = '{"m2r_basic",      1'b0, 10'd5,    10'd9,    11'd3, 1'b0, 10};
        vecs[1] = '{"r2m_crypt",      1'b1, 10'd20,   10'd40,   11'd1, 1'b1, 4};
        vecs[2] = '{"len_zero",       1'b0, 10'd7,    10'd8,    11'd0, 1'b0, 2};
        vecs[3] = '{"src_wrap",       1'b0, 10'd1023, 10'd100,  11'd2, 1'b0, 7};
        vecs[4] = '{"dst_wrap_crypt", 1'b1, 10'd3,    10'd1022, 11'd3, 1'b1, 10};
        vecs[5] = '{"m2r_crypt",      1'b0, 10'd500,  10'd600,  11'd2, 1'b1, 7};

        rst = 1'b1; start = 1'b0; dir = 1'b0; crypt = 1'b0; abort = 1'b0;
        src_base = '0; dst_base = '0; len = '0;
        key_mem = 16'h1234; key_reg = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst we", {mem_we, reg_we, sec_en}, 3'b000);
        chk("rst addr", {mem_addr, reg_addr}, 20'd0);
        chk("rst data", mem_wdata | reg_wdata | sec_din, 32'd0);
        rst = 1'b0;

        // Abort in the second WAIT of a 4-word copy; a start issued while busy is ignored.
        clear_mon();
        do_start(1'b0, 10'd50, 10'd60, 11'd4, 1'b0);
        @(posedge clk);
        @(negedge clk);
        dir = 1'b1; src_base = 10'd200; dst_base = 10'd300; len = 11'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort busy_before", busy, 1'b1);
        abort = 1'b1;
        #1;
        chk("abort no_we", {mem_we, reg_we}, 2'b00);
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort write_count", wlog.size(), 1);
        if (wlog.size() > 0) begin
            chk("abort wr_addr", wlog[0].addr, 10'd60);
            chk("abort wr_data", wlog[0].data, mem_init(10'd50));
        end
        chk("abort err", err, 1'b1);
        chk("abort busy_after", busy, 1'b0);
        chk("abort done_never", done_cnt, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Mismatched keys on start.
        clear_mon();
        key_reg = 16'h1235;
        do_start(1'b0, 10'd30, 10'd31, 11'd2, 1'b0);
        key_reg = 16'h1234;
        wait_done(lat);
        @(negedge clk);
`ifdef SEC_XFER_KEY_CHECK_EN
        chk("key done_latency", lat, 1);
        chk("key write_count", wlog.size(), 0);
        chk("key err", err, 1'b1);
`else
        chk("key done_latency", lat, 7);
        chk("key write_count", wlog.size(), 2);
        chk("key err", err, 1'b0);
`endif
        chk("key done_count", done_cnt, 1);

        // Reset raised during the first WR must suppress that write.
        clear_mon();
        do_start(1'b0, 10'd10, 10'd20, 11'd3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst no_we", {mem_we, reg_we}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        chk("midrst busy", busy, 1'b0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst write_count", wlog.size(), 0);
        chk("midrst done_count", done_cnt, 0);
        chk("midrst busy_after", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sec_xfer_ctrl.md
SEC_XFER_CTRL -- requirements
Module: sec_xfer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory and register-file address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter LEN_W, default 11, transfer-length width (max 1024 words).
REQ-004 SHALL have a single clock and a synchronous active-high reset.
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active high
- start  in  1  request pulse, sampled only in IDLE
- dir  in  1  0 = memory->register, 1 = register->memory
- src_base  in  ADDR_W  first source address
- dst_base  in  ADDR_W  first destination address
- len  in  LEN_W  word count
- crypt  in  1  route words through the security block
- abort  in  1  cancel the transfer in progress
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag, cleared by the next accepted start
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one-cycle read latency
- reg_addr  out  ADDR_W  register-file address
- reg_we  out  1  register-file write enable
- reg_wdata  out  DATA_W  register-file write data
- reg_rdata  in  DATA_W  register-file read data, one-cycle read latency
- sec_din  out  DATA_W  word to the security block
- sec_en  out  1  security block enable
- sec_dout  in  DATA_W  security block result, combinational from sec_din
- key_mem  in  16  memory key_access
- key_reg  in  16  register key_access

Function
REQ-006 SHALL implement the FSM IDLE -> RD -> WAIT -> WR -> (RD | DONE) -> IDLE.
REQ-007 SHALL, in IDLE with start=1, latch dir, src_base, dst_base, len and crypt, clear the word count, and go to RD next cycle; if len=0 it SHALL go directly to DONE and perform no writes.
REQ-008 SHALL, in RD, drive the source address (src_base+count) on the source port with both write enables 0.
REQ-009 SHALL, in WAIT, hold the source address while the source read data returns.
REQ-010 SHALL, in WR, present the captured word to sec_din, assert sec_en=crypt, drive the destination address (dst_base+count) with write data = sec_dout if crypt else the raw word, and assert exactly one write enable for exactly one cycle.
REQ-011 SHALL, after WR, increment count and go to DONE if count+1 = len, else to RD.
REQ-012 SHALL pulse done=1 for the single DONE cycle and return to IDLE on the next cycle.
REQ-013 SHALL, for length L >= 1, assert done exactly 3L+1 cycles after the start-sampling edge.
REQ-014 SHALL compute addresses modulo 2^ADDR_W, so 1023+1 wraps to 0.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL give abort priority over start and all state transitions: the next state is IDLE, no write fires in the cycle abort is high, done stays 0 and err is set.
REQ-017 SHALL drive the inactive port's address to 0 and keep mem_we and reg_we low outside WR.

Reset
REQ-018 SHALL force, while rst=1, state=IDLE, count=0 and all outputs to 0 (busy, done, err, both we, addresses, data and sec_en).
REQ-019 SHALL let reset asserted mid-transfer take effect at the next edge with no further writes.

Configuration
REQ-020 SHALL, with SEC_XFER_KEY_CHECK_EN defined, compare key_mem and key_reg in IDLE when start is accepted; on mismatch it SHALL go to DONE, set err and perform no writes.
REQ-021 SHALL, without SEC_XFER_KEY_CHECK_EN, ignore key_mem and key_reg.

Structure
REQ-022 SHALL import the state enum (IDLE, RD, WAIT, WR, DONE) and the DIR_M2R/DIR_R2M constants from the shared package sec_xfer_pkg.
REQ-023 SHALL remain a single module with no sub-module; the memory, registers and security blocks stay external.

Verification
REQ-024 SHALL cover: start, dir=0, src=5, dst=9, len=3, crypt=0 -> reg writes at 9, 10, 11 with mem[5..7]; done 10 cycles after start.
REQ-025 SHALL cover: dir=1, crypt=1, len=1 -> one mem_we carrying sec_dout of reg[src]; sec_en high only in WR.
REQ-026 SHALL cover: len=0 -> no writes; done 2 cycles after start.
REQ-027 SHALL cover: src=1023, len=2 -> reads at 1023 then 0.
REQ-028 SHALL cover: abort in the 2nd WAIT of len=4 -> one write only, err=1, done never; a start in that busy window is ignored.
REQ-029 SHALL cover: with SEC_XFER_KEY_CHECK_EN, key_mem=16'h1234, key_reg=16'h1235 -> no writes, err=1, done pulses.
